// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control stage.
// Drives the PC register's CLR/INC/LOAD controls, requests the instruction at
// the current PC from memory, latches it into IR and hands it to the decoder
// over a valid/ready handshake. Branch redirects and halts are applied only at
// the handoff edge.
// Optional feature: define FETCH_TIMEOUT_EN to bound the memory wait to
// TIMEOUT_CYC cycles. A timeout raises a sticky FETCH_ERR and halts the
// sequencer. When the macro is not defined, FETCH_ERR is tied to 0.
module fetch_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 19,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [ADDR_W-1:0]  PC_VAL,
    output logic               PC_LOAD,
    output logic               PC_INC,
    output logic               PC_CLR,
    output logic [ADDR_W-1:0]  PC_TARGET,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic               MEM_REQ,
    input  logic               MEM_ACK,
    input  logic [INSTR_W-1:0] MEM_DATA,
    output logic [INSTR_W-1:0] IR,
    output logic               IR_VALID,
    input  logic               IR_READY,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET,
    input  logic               HALT,
    output logic               FETCH_ERR
);

    typedef enum logic [2:0] {
        S_CLR    = 3'd0,
        S_REQ    = 3'd1,
        S_HOLD   = 3'd2,
        S_SETTLE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // A timeout limit outside the 8-bit counter range cannot be built.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYC must be within 1..255");
    end

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_pc_load;
    logic                 r_pc_inc;
    logic                 r_pc_clr;
    logic [ADDR_W-1:0]    r_pc_target;
    logic                 r_mem_req;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_ir_valid;

    logic                 w_pc_load_nxt;
    logic                 w_pc_inc_nxt;
    logic                 w_pc_clr_nxt;
    logic [ADDR_W-1:0]    w_pc_target_nxt;
    logic                 w_mem_req_nxt;
    logic [INSTR_W-1:0]   w_ir_nxt;
    logic                 w_ir_valid_nxt;

`ifdef FETCH_TIMEOUT_EN
    // Counter value at which one more ACK-less cycle reaches the limit.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0]           r_wait_cnt;
    logic [7:0]           w_wait_cnt_nxt;
    logic                 r_fetch_err;
    logic                 w_fetch_err_nxt;
`endif

    // Memory address follows the PC register directly; the PC is held stable
    // for the whole request because no PC pulse is issued in S_REQ.
    assign MEM_ADDR  = PC_VAL;
    assign PC_LOAD   = r_pc_load;
    assign PC_INC    = r_pc_inc;
    assign PC_CLR    = r_pc_clr;
    assign PC_TARGET = r_pc_target;
    assign MEM_REQ   = r_mem_req;
    assign IR        = r_ir;
    assign IR_VALID  = r_ir_valid;
`ifdef FETCH_TIMEOUT_EN
    assign FETCH_ERR = r_fetch_err;
`else
    assign FETCH_ERR = 1'b0;
`endif

    // Next-state and next-output decode; every PC pulse defaults to 0 so each
    // is at most one cycle wide and only one can be set per transition.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_load_nxt   = 1'b0;
        w_pc_inc_nxt    = 1'b0;
        w_pc_clr_nxt    = 1'b0;
        w_pc_target_nxt = r_pc_target;
        w_mem_req_nxt   = 1'b0;
        w_ir_nxt        = r_ir;
        w_ir_valid_nxt  = r_ir_valid;
`ifdef FETCH_TIMEOUT_EN
        w_wait_cnt_nxt  = r_wait_cnt;
        w_fetch_err_nxt = r_fetch_err;
`endif
        case (r_state)
            S_CLR: begin
                w_pc_clr_nxt = 1'b1;
                w_state_nxt  = S_SETTLE;
            end
            S_SETTLE: begin
                w_mem_req_nxt = 1'b1;
                w_state_nxt   = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                w_wait_cnt_nxt = 8'd0;
`endif
            end
            S_REQ: begin
                if (MEM_ACK) begin
                    w_ir_nxt       = MEM_DATA;
                    w_ir_valid_nxt = 1'b1;
                    w_pc_inc_nxt   = 1'b1;
                    w_mem_req_nxt  = 1'b0;
                    w_state_nxt    = S_HOLD;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (r_wait_cnt == TIMEOUT_LAST) begin
                        w_mem_req_nxt   = 1'b0;
                        w_fetch_err_nxt = 1'b1;
                        w_state_nxt     = S_HALT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                        w_mem_req_nxt  = 1'b1;
                    end
`else
                    w_mem_req_nxt = 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (r_ir_valid && IR_READY) begin
                    w_ir_valid_nxt = 1'b0;
                    if (BR_TAKEN) begin
                        w_pc_target_nxt = BR_TARGET;
                        w_pc_load_nxt   = 1'b1;
                    end else begin
                        w_pc_target_nxt = r_pc_target;
                    end
                    if (HALT) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_SETTLE;
                    end
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HALT: begin
                w_ir_valid_nxt = 1'b0;
                w_state_nxt    = S_HALT;
            end
            default: begin
                w_ir_valid_nxt = 1'b0;
                w_state_nxt    = S_CLR;
            end
        endcase
    end

    // State register; reset parks the sequencer in S_CLR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs; reset drops the request and valid asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc_load   <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_pc_clr    <= 1'b0;
            r_pc_target <= '0;
            r_mem_req   <= 1'b0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
        end else begin
            r_pc_load   <= w_pc_load_nxt;
            r_pc_inc    <= w_pc_inc_nxt;
            r_pc_clr    <= w_pc_clr_nxt;
            r_pc_target <= w_pc_target_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_ir        <= w_ir_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory-wait counter and sticky timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt  <= 8'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_fetch_err <= w_fetch_err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default build).
// The bench models the downstream PC register and the instruction memory
// inline; memory answers one cycle after it first sees MEM_REQ.
module tb_fetch_sequencer;

    logic        CLK;
    logic        RST;
    logic [11:0] pc;
    logic        PC_LOAD;
    logic        PC_INC;
    logic        PC_CLR;
    logic [11:0] PC_TARGET;
    logic [11:0] MEM_ADDR;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic [18:0] MEM_DATA;
    logic [18:0] IR;
    logic        IR_VALID;
    logic        IR_READY;
    logic        BR_TAKEN;
    logic [11:0] BR_TARGET;
    logic        HALT;
    logic        FETCH_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_req    = 0;
    logic halt_bad;

    fetch_sequencer #(.ADDR_W(12), .INSTR_W(19), .TIMEOUT_CYC(255)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_VAL    (pc),
        .PC_LOAD   (PC_LOAD),
        .PC_INC    (PC_INC),
        .PC_CLR    (PC_CLR),
        .PC_TARGET (PC_TARGET),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_REQ   (MEM_REQ),
        .MEM_ACK   (MEM_ACK),
        .MEM_DATA  (MEM_DATA),
        .IR        (IR),
        .IR_VALID  (IR_VALID),
        .IR_READY  (IR_READY),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .HALT      (HALT),
        .FETCH_ERR (FETCH_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the PC register model applies the pulses seen before the edge.
    task automatic tick();
        logic        c;
        logic        l;
        logic        i;
        logic [11:0] t;
        c = PC_CLR;
        l = PC_LOAD;
        i = PC_INC;
        t = PC_TARGET;
        @(posedge CLK);
        #1;
        if (c) pc = 12'h000;
        else if (l) pc = t;
        else if (i) pc = pc + 12'd1;
        cyc++;
    endtask

    // Called right after MEM_REQ rises; returns just after the ACK edge k.
    task automatic do_fetch(input logic [11:0] a, input logic [18:0] d);
        chk("req_up", {31'd0, MEM_REQ}, 32'd1);
        chk("req_addr", {20'd0, MEM_ADDR}, {20'd0, a});
        tick();
        chk("req_wait", {31'd0, MEM_REQ}, 32'd1);
        chk("valid_wait", {31'd0, IR_VALID}, 32'd0);
        chk("addr_stable", {20'd0, MEM_ADDR}, {20'd0, a});
        MEM_ACK  = 1'b1;
        MEM_DATA = d;
        tick();
        MEM_ACK  = 1'b0;
        MEM_DATA = 19'h7FFFF;
        chk("ir_latch", {13'd0, IR}, {13'd0, d});
        chk("ir_valid", {31'd0, IR_VALID}, 32'd1);
        chk("req_drop", {31'd0, MEM_REQ}, 32'd0);
        chk("pc_inc", {31'd0, PC_INC}, 32'd1);
        chk("no_load_at_ack", {31'd0, PC_LOAD}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; pc = 12'h5A5; MEM_ACK = 1'b0; MEM_DATA = 19'h0;
        IR_READY = 1'b1; BR_TAKEN = 1'b0; BR_TARGET = 12'h000; HALT = 1'b0;
        halt_bad = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_valid", {31'd0, IR_VALID}, 32'd0);
        chk("rst_clr", {31'd0, PC_CLR}, 32'd0);
        chk("rst_ir", {13'd0, IR}, 32'd0);
        chk("rst_target", {20'd0, PC_TARGET}, 32'd0);
        chk("rst_err", {31'd0, FETCH_ERR}, 32'd0);

        // Test 1: clear, then back-to-back fetches at 0, 1, 2
        RST = 1'b0;
        tick();
        chk("clr_pulse", {31'd0, PC_CLR}, 32'd1);
        chk("clr_noreq", {31'd0, MEM_REQ}, 32'd0);
        tick();
        chk("clr_once", {31'd0, PC_CLR}, 32'd0);
        t_req = cyc;
        do_fetch(12'h000, 19'h12345);
        tick();
        chk("hand0_valid", {31'd0, IR_VALID}, 32'd0);
        chk("hand0_inc", {31'd0, PC_INC}, 32'd0);
        chk("hand0_addr", {20'd0, MEM_ADDR}, 32'h001);
        tick();
        chk("period1", cyc - t_req, 32'd4);
        t_req = cyc;
        do_fetch(12'h001, 19'h0ABCD);
        tick();
        tick();
        chk("period2", cyc - t_req, 32'd4);
        do_fetch(12'h002, 19'h7F00F);
        tick();
        tick();

        // Test 2: decoder stalls 5 cycles
        IR_READY = 1'b0;
        do_fetch(12'h003, 19'h55AA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ir", {13'd0, IR}, 32'h55AA5);
            chk("stall_valid", {31'd0, IR_VALID}, 32'd1);
            chk("stall_req", {31'd0, MEM_REQ}, 32'd0);
            chk("stall_inc", {31'd0, PC_INC}, 32'd0);
            chk("stall_addr", {20'd0, MEM_ADDR}, 32'h004);
        end
        IR_READY = 1'b1;
        tick();
        chk("stall_hand", {31'd0, IR_VALID}, 32'd0);
        tick();

        // Test 3: branch to 0x010, then 0x3A5 from a held instruction
        do_fetch(12'h004, 19'h00001);
        BR_TAKEN = 1'b1;
        BR_TARGET = 12'h010;
        tick();
        chk("br1_load", {31'd0, PC_LOAD}, 32'd1);
        chk("br1_target", {20'd0, PC_TARGET}, 32'h010);
        chk("br1_inc", {31'd0, PC_INC}, 32'd0);
        BR_TARGET = 12'h7FF;
        IR_READY = 1'b0;
        tick();
        chk("br1_pulse", {31'd0, PC_LOAD}, 32'd0);
        do_fetch(12'h010, 19'h6DB6D);
        tick();
        chk("br_ignored_load", {31'd0, PC_LOAD}, 32'd0);
        chk("br_ignored_tgt", {20'd0, PC_TARGET}, 32'h010);
        chk("br_hold_valid", {31'd0, IR_VALID}, 32'd1);
        BR_TARGET = 12'h3A5;
        IR_READY = 1'b1;
        tick();
        chk("br2_load", {31'd0, PC_LOAD}, 32'd1);
        chk("br2_target", {20'd0, PC_TARGET}, 32'h3A5);
        chk("br2_valid", {31'd0, IR_VALID}, 32'd0);
        BR_TAKEN = 1'b0;
        tick();
        chk("br2_pulse", {31'd0, PC_LOAD}, 32'd0);

        // Test 4: halt at handoff, quiet for 50 cycles, then reset restarts
        do_fetch(12'h3A5, 19'h2468A);
        HALT = 1'b1;
        tick();
        chk("halt_valid", {31'd0, IR_VALID}, 32'd0);
        HALT = 1'b0;
        for (int i = 0; i < 50; i++) begin
            MEM_ACK  = (i % 7 == 3);
            BR_TAKEN = (i % 5 == 1);
            tick();
            halt_bad = halt_bad | MEM_REQ | PC_LOAD | PC_INC | PC_CLR | IR_VALID;
        end
        MEM_ACK = 1'b0;
        BR_TAKEN = 1'b0;
        chk("halt_quiet", {31'd0, halt_bad}, 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("restart_clr", {31'd0, PC_CLR}, 32'd1);
        tick();
        chk("restart_addr", {20'd0, MEM_ADDR}, 32'h000);
        chk("restart_req", {31'd0, MEM_REQ}, 32'd1);

        // Test 5: reset while awaiting ACK
        tick();
        chk("await_req", {31'd0, MEM_REQ}, 32'd1);
        #3;
        RST = 1'b1;
        #1;
        chk("async_req", {31'd0, MEM_REQ}, 32'd0);
        chk("async_valid", {31'd0, IR_VALID}, 32'd0);
        MEM_ACK = 1'b1;
        MEM_DATA = 19'h7FFFF;
        tick();
        tick();
        chk("late_ack_ir", {13'd0, IR}, 32'd0);
        RST = 1'b0;
        tick();
        chk("late_ack_clr", {31'd0, PC_CLR}, 32'd1);
        chk("late_ack_valid", {31'd0, IR_VALID}, 32'd0);
        chk("late_ack_ir2", {13'd0, IR}, 32'd0);
        MEM_ACK = 1'b0;
        tick();
        do_fetch(12'h000, 19'h13579);
        tick();
        chk("final_valid", {31'd0, IR_VALID}, 32'd0);
        chk("final_err", {31'd0, FETCH_ERR}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
